seq_det_prog: RTL and testbench

Programmable serial pattern detector. It is the parametrised successor to the fixed 4-bit "1011" detector.
- Pattern value, pattern length (1..PAT_W) and overlap mode are loaded at run time.
- A qualified serial bit stream is accepted, one bit per enabled cycle.
- A registered one-cycle match pulse is produced, plus an optional saturating match counter.
- Sits between a serial front end (deserialiser/sampler) and control logic that reacts to sync words.

---
 rtl/seq_det_pkg.sv | 23 ++
 rtl/seq_det_match.sv | 26 ++
 rtl/seq_det_prog.sv | 120 ++++++++++++
 tb/tb_seq_det_prog.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable sequence detector.
// State encoding, default sizes and length clamping.
package seq_det_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } state_t;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  // 0 means 1; anything above the maximum means the maximum
  function automatic int clamp_len(
    input int len,
    input int pat_w
  );
    if (len < 1) return 1;
    if (len > pat_w) return pat_w;
    return len;
  endfunction

endpackage

// File: rtl/seq_det_match.sv
// Masked compare of shift history against the pattern.
// Ports: hist, pattern, len (active bits from bit 0) -> hit.
module seq_det_match
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic [PAT_W-1:0] hist,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);

  logic [PAT_W-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
  end

  assign hit = (((hist ^ pattern) & mask) == '0);

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector with registered match pulse.
// Ports: clk, rst (async, low), cfg_load/cfg_pattern/cfg_len/
// cfg_overlap, en, a -> out, busy; match_cnt with SEQ_DET_MATCH_CNT_EN.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
`ifdef SEQ_DET_MATCH_CNT_EN
  parameter int CNT_W = CNT_W_DEF,
`endif
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             en,
  input  logic             a,
  output logic             out,
  output logic             busy
`ifdef SEQ_DET_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  state_t           state, state_n;
  logic [PAT_W-1:0] pat, pat_n;
  logic [LEN_W-1:0] len, len_n;
  logic             ovl, ovl_n;
  logic [PAT_W-1:0] hist, hist_n;
  logic [LEN_W-1:0] fill, fill_n;
  logic             out_n;

  logic [PAT_W-1:0] hist_sh;
  logic [LEN_W-1:0] fill_inc;
  logic             hit;
  logic             match;

  assign hist_sh  = {hist[PAT_W-2:0], a};
  assign fill_inc = (fill == LEN_W'(PAT_W)) ?
                    fill : fill + LEN_W'(1);

  seq_det_match #(
    .PAT_W (PAT_W)
  ) u_match (
    .hist    (hist_sh),
    .pattern (pat),
    .len     (len),
    .hit     (hit)
  );

  // a load in the same cycle discards the sample
  assign match = (state == ST_SEARCH) && en && !cfg_load &&
                 (fill_inc >= len) && hit;

  always_comb begin
    state_n = state;
    pat_n   = pat;
    len_n   = len;
    ovl_n   = ovl;
    hist_n  = hist;
    fill_n  = fill;
    out_n   = 1'b0;
    if (cfg_load) begin
      state_n = ST_SEARCH;
      pat_n   = cfg_pattern;
      len_n   = LEN_W'(clamp_len(int'(cfg_len), PAT_W));
      ovl_n   = cfg_overlap;
      hist_n  = '0;
      fill_n  = '0;
    end else if (state == ST_SEARCH && en) begin
      out_n = match;
      if (match && !ovl) begin
        hist_n = '0;
        fill_n = '0;
      end else begin
        hist_n = hist_sh;
        fill_n = fill_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      pat   <= '0;
      len   <= LEN_W'(1);
      ovl   <= 1'b0;
      hist  <= '0;
      fill  <= '0;
      out   <= 1'b0;
    end else begin
      state <= state_n;
      pat   <= pat_n;
      len   <= len_n;
      ovl   <= ovl_n;
      hist  <= hist_n;
      fill  <= fill_n;
      out   <= out_n;
    end
  end

  assign busy = (state == ST_SEARCH);

`ifdef SEQ_DET_MATCH_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt <= '0;
    end else if (cfg_load) begin
      match_cnt <= '0;
    end else if (match && match_cnt != '1) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Randomised self-checking bench for seq_det_prog.
// Reference model keeps received bits in a queue.
module tb_seq_det_prog;

  localparam int PW = 8;
  localparam int LW = 4;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_load;
  logic [PW-1:0] cfg_pattern;
  logic [LW-1:0] cfg_len;
  logic          cfg_overlap;
  logic          en;
  logic          a;
  logic          out;
  logic          busy;
`ifdef SEQ_DET_MATCH_CNT_EN
  logic [1:0]    match_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  bit            m_search;
  logic [PW-1:0] m_pat;
  int            m_len;
  bit            m_ovl;
  int            q[$];
  int            m_cnt;
  bit            m_out;

  seq_det_prog #(
`ifdef SEQ_DET_MATCH_CNT_EN
    .CNT_W (2),
`endif
    .PAT_W (PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .en          (en),
    .a           (a),
    .out         (out),
`ifdef SEQ_DET_MATCH_CNT_EN
    .match_cnt   (match_cnt),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_search = 0;
    m_pat    = '0;
    m_len    = 1;
    m_ovl    = 0;
    q.delete();
    m_cnt    = 0;
    m_out    = 0;
  endtask

  task automatic model_edge();
    bit hit;
    m_out = 0;
    if (cfg_load) begin
      m_search = 1;
      m_pat    = cfg_pattern;
      m_len    = (cfg_len == 0) ? 1 :
                 (int'(cfg_len) > PW) ? PW : int'(cfg_len);
      m_ovl    = cfg_overlap;
      q.delete();
      m_cnt    = 0;
    end else if (m_search && en) begin
      q.push_back(int'(a));
      if (q.size() > PW) void'(q.pop_front());
      if (q.size() >= m_len) begin
        hit = 1;
        for (int k = 0; k < m_len; k++)
          if (q[q.size()-1-k] != int'(m_pat[k])) hit = 0;
        if (hit) begin
          m_out = 1;
          if (m_cnt < CMAX) m_cnt++;
          if (!m_ovl) q.delete();
        end
      end
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".out"}, 32'(out), 32'(m_out));
    chk({tag, ".busy"}, 32'(busy), 32'(m_search));
`ifdef SEQ_DET_MATCH_CNT_EN
    chk({tag, ".cnt"}, 32'(match_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs(tag);
  endtask

  task automatic load(
    input logic [PW-1:0] p,
    input logic [LW-1:0] l,
    input logic          o,
    input logic          e,
    input logic          b
  );
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_load    = 1'b1;
    en          = e;
    a           = b;
    step("load");
    cfg_load    = 1'b0;
  endtask

  task automatic bit1(input logic e, input logic b);
    en = e;
    a  = b;
    step("bit");
  endtask

  task automatic feed(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bit1(1'b1, v[i]);
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1 model_reset();
    check_outs("rst_now");
    @(posedge clk);
    #1 check_outs("rst_hold");
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    cfg_load = 0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 0; en = 0; a = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outs("reset");
    rst = 1'b1;

    // idle ignores data
    bit1(1, 0); bit1(1, 1); bit1(1, 0);

    // overlapping baseline
    load(8'h0B, 4'd4, 1, 0, 0);
    feed(16'b1011011, 7);
`ifdef SEQ_DET_MATCH_CNT_EN
    chk("base_cnt", 32'(match_cnt), 32'd2);
`endif

    // non-overlapping
    load(8'h0B, 4'd4, 0, 0, 0);
    feed(16'b1011011, 7);
`ifdef SEQ_DET_MATCH_CNT_EN
    chk("novl_cnt", 32'(match_cnt), 32'd1);
`endif

    // en gaps
    load(8'h0B, 4'd4, 1, 0, 0);
    bit1(1, 1); bit1(1, 0);
    bit1(0, 1); bit1(0, 0); bit1(0, 1);
    bit1(1, 1); bit1(1, 1);

    // load collision mid-pattern
    load(8'h0B, 4'd4, 1, 0, 0);
    feed(16'b101, 3);
    load(8'h0B, 4'd4, 1, 1, 1);
    feed(16'b1011, 4);

    // len 0 clamps to 1, counter saturation
    load(8'h01, 4'd0, 1, 0, 0);
    repeat (5) bit1(1, 1);
    chk("len1_out", 32'(out), 32'd1);

    // len 15 clamps to 8
    load(8'hA5, 4'd15, 1, 0, 0);
    feed(16'h5A5, 12);

    // async reset mid-stream
    load(8'h0B, 4'd4, 1, 0, 0);
    feed(16'b101, 3);
    async_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    bit1(1, 1); bit1(1, 0); bit1(1, 0);
    load(8'h0B, 4'd4, 1, 0, 0);
    feed(16'b1011, 4);

    // randomised traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 999) < 3) begin
        async_reset();
      end else if ($urandom_range(0, 99) < 4) begin
        load(PW'($urandom), LW'($urandom_range(0, 15)),
             1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        bit1(($urandom_range(0, 3) != 0), 1'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
